// File: rtl/bnn_stream_frontend_pkg.sv
// bnn_stream_frontend_pkg: shared state encoding and winered default geometry
package bnn_stream_frontend_pkg;
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;
    localparam int WR_FEAT_CNT  = 11;
    localparam int WR_FEAT_BITS = 4;
    localparam int WR_CLASS_CNT = 6;
endpackage

// File: rtl/bnn_stream_frontend_feat_packer.sv
// bnn_stream_frontend_feat_packer: beat index counter plus feature vector register;
// beat k lands MSB-first so the vector matches memh digit order.
module bnn_stream_frontend_feat_packer #(
    parameter int FEAT_CNT  = 11,
    parameter int FEAT_BITS = 4,
    parameter int IW        = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr,
    input  logic                          clr,
    input  logic [FEAT_BITS-1:0]          data,
    output logic [IW-1:0]                 idx,
    output logic [FEAT_CNT*FEAT_BITS-1:0] vec
);
    logic [IW-1:0]                 idx_d, idx_q;
    logic [FEAT_CNT*FEAT_BITS-1:0] vec_d, vec_q;

    always_comb begin
        idx_d = clr ? '0 : wr ? idx_q + 1'b1 : idx_q;
        vec_d = vec_q;
        if (wr)
            vec_d[(FEAT_CNT-1-int'(idx_q))*FEAT_BITS +: FEAT_BITS] = data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            vec_q <= '0;
        end else begin
            idx_q <= idx_d;
            vec_q <= vec_d;
        end
    end

    assign idx = idx_q;
    assign vec = vec_q;
endmodule

// File: rtl/bnn_stream_frontend.sv
// bnn_stream_frontend: packs streamed feature nibbles for a combinational BNN,
// waits a settle time, then returns the prediction on a valid/ready port.
module bnn_stream_frontend
    import bnn_stream_frontend_pkg::*;
#(
    parameter int FEAT_CNT      = WR_FEAT_CNT,
    parameter int FEAT_BITS     = WR_FEAT_BITS,
    parameter int CLASS_CNT     = WR_CLASS_CNT,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_BITS      = 16,
    localparam int CW           = $clog2(CLASS_CNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [FEAT_BITS-1:0]          s_data,
    input  logic                          s_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [CW-1:0]                 prediction,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CW-1:0]                 m_class,
    output logic [IDX_BITS-1:0]           m_index,
    input  logic                          err_clr,
    output logic                          frame_err
);
    localparam int IW    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic                m_valid_d, m_valid_q;
    logic [CW-1:0]       m_class_d, m_class_q;
    logic [IDX_BITS-1:0] m_index_d, m_index_q;
    logic                frame_err_d, frame_err_q;
    logic                err_set, s_fire, wr, clr, last_beat;
    logic [IW-1:0]       idx;

    assign s_ready   = (state_q == LOAD) || (state_q == DRAIN);
    assign s_fire    = s_valid && s_ready;
    assign last_beat = (idx == IW'(FEAT_CNT-1));
    assign wr        = s_fire && (state_q == LOAD);
    // any vector-ending beat in LOAD (good, long or short) rewinds the index
    assign clr       = wr && (s_last || last_beat);

    bnn_stream_frontend_feat_packer #(
        .FEAT_CNT  (FEAT_CNT),
        .FEAT_BITS (FEAT_BITS),
        .IW        (IW)
    ) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .clr   (clr),
        .data  (s_data),
        .idx   (idx),
        .vec   (features)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_index_d = m_index_q;
        err_set   = 1'b0;
        case (state_q)
            LOAD: if (s_fire) begin
                if (last_beat) begin
                    state_d = s_last ? SETTLE : DRAIN;
                    cnt_d   = CNT_W'(SETTLE_CYCLES-1);
                    err_set = !s_last;
                end else begin
                    err_set = s_last;
                end
            end
            DRAIN: if (s_fire && s_last) state_d = LOAD;
            SETTLE: if (cnt_q == '0) begin
                state_d   = OUT;
                m_valid_d = 1'b1;
                m_class_d = prediction;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            OUT: if (m_ready) begin
                state_d   = LOAD;
                m_valid_d = 1'b0;
                m_index_d = m_index_q + 1'b1;
            end
            default: state_d = LOAD;
        endcase
        frame_err_d = err_set || (frame_err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            m_index_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_class_q   <= m_class_d;
            m_index_q   <= m_index_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign m_index   = m_index_q;
    assign frame_err = frame_err_q;
endmodule
